// File: rtl/mem_streams_align.sv
// Multi-lane stream buffer: independent per-lane writes, lockstep block reads.
// A block of BLOCK_LEN words is released once every lane holds a full block.
module mem_streams_align #(
    parameter int CHANNELS     = 16,
    parameter int WDATA_WIDTH  = 64,
    parameter int ADDR_WIDTH   = 11,
    parameter int BLOCK_LEN    = 1024,
    parameter int READ_LATENCY = 2,
    localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1,
    localparam int PTR_W = ADDR_WIDTH + 1
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic [CHANNELS-1:0]             i_wr_wen,
    input  logic [CHANNELS*WDATA_WIDTH-1:0] i_wr_data,
    input  logic                            i_rd_ren,
    input  logic                            i_clr_ovf,
    output logic [CHANNELS*WDATA_WIDTH-1:0] o_rd_data,
    output logic [CNT_W-1:0]                o_rd_addr,
    output logic                            o_tvalid,
    output logic                            o_tlast,
    output logic [PTR_W-1:0]                o_min_fill,
    output logic [CHANNELS-1:0]             o_overflow,
    output logic                            o_busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int RL    = READ_LATENCY;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] BLEN_P  = PTR_W'(BLOCK_LEN);
    localparam logic [CNT_W-1:0] LAST_IX = CNT_W'(BLOCK_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_GAP
    } state_t;

    state_t state_q, state_d;
    logic gap_q, gap_d;
    logic [PTR_W-1:0] wr_ptr_q [CHANNELS];
    logic [PTR_W-1:0] wr_ptr_d [CHANNELS];
    logic [PTR_W-1:0] occ [CHANNELS];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] min_fill_q, min_fill_d;
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic [CHANNELS-1:0] full, wr_acc;
    logic issue;

    logic [RL-1:0] vld_q, vld_d;
    logic [RL-1:0] last_q, last_d;
    logic [CNT_W-1:0] addr_q [RL];
    logic [CNT_W-1:0] addr_d [RL];
    logic [CHANNELS*WDATA_WIDTH-1:0] data_q [RL];

    logic [WDATA_WIDTH-1:0] ram [CHANNELS][DEPTH];

    // Fullness is judged on pre-cycle occupancy; a same-cycle read never frees room.
    always_comb begin
        min_fill_d = DEPTH_P;
        for (int c = 0; c < CHANNELS; c++) begin
            occ[c]      = wr_ptr_q[c] - rd_ptr_q;
            full[c]     = (occ[c] == DEPTH_P);
            wr_acc[c]   = i_wr_wen[c] & ~full[c];
            wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(wr_acc[c]);
            if (occ[c] < min_fill_d) begin
                min_fill_d = occ[c];
            end
        end
        ovf_d = (i_clr_ovf ? '0 : ovf_q) | (i_wr_wen & full);
    end

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        issue    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (min_fill_q >= BLEN_P) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (i_rd_ren) begin
                    issue    = 1'b1;
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    if (cnt_q == LAST_IX) begin
                        cnt_d   = '0;
                        gap_d   = 1'b0;
                        state_d = S_GAP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_GAP: begin
                // Two cycles let the registered min-fill see the drained block.
                gap_d = 1'b1;
                if (gap_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        vld_d[0]  = issue;
        last_d[0] = issue & (cnt_q == LAST_IX);
        addr_d[0] = cnt_q;
        for (int i = 1; i < RL; i++) begin
            vld_d[i]  = vld_q[i-1];
            last_d[i] = last_q[i-1];
            addr_d[i] = addr_q[i-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            gap_q      <= 1'b0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            min_fill_q <= '0;
            ovf_q      <= '0;
            vld_q      <= '0;
            last_q     <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= '0;
            end
            for (int i = 0; i < RL; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            min_fill_q <= min_fill_d;
            ovf_q      <= ovf_d;
            vld_q      <= vld_d;
            last_q     <= last_d;
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
            end
            for (int i = 0; i < RL; i++) begin
                addr_q[i] <= addr_d[i];
            end
        end
    end

    // Storage and data pipe carry no reset; data is qualified by the valid pipe.
    always_ff @(posedge i_clk) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_acc[c]) begin
                ram[c][wr_ptr_q[c][ADDR_WIDTH-1:0]] <=
                    i_wr_data[c*WDATA_WIDTH +: WDATA_WIDTH];
            end
            data_q[0][c*WDATA_WIDTH +: WDATA_WIDTH] <=
                ram[c][rd_ptr_q[ADDR_WIDTH-1:0]];
        end
        for (int i = 1; i < RL; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign o_rd_data  = data_q[RL-1];
    assign o_rd_addr  = addr_q[RL-1];
    assign o_tvalid   = vld_q[RL-1];
    assign o_tlast    = last_q[RL-1];
    assign o_min_fill = min_fill_q;
    assign o_overflow = ovf_q;
    assign o_busy     = (state_q == S_READ);

endmodule

// File: tb/tb_mem_streams_align.sv
// Bench for mem_streams_align: queue-based lane model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mem_streams_align;

    localparam int CH    = 4;
    localparam int W     = 16;
    localparam int AW    = 3;
    localparam int BL    = 4;
    localparam int RL    = 2;
    localparam int DEPTH = 8;
    localparam int CW    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [CH-1:0] wen;
    logic [CH*W-1:0] wdata;
    logic ren, clr;
    logic [CH*W-1:0] o_rd_data;
    logic [CW-1:0] o_rd_addr;
    logic o_tvalid, o_tlast, o_busy;
    logic [AW:0] o_min_fill;
    logic [CH-1:0] o_overflow;

    mem_streams_align #(
        .CHANNELS(CH), .WDATA_WIDTH(W), .ADDR_WIDTH(AW),
        .BLOCK_LEN(BL), .READ_LATENCY(RL)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_wr_wen(wen), .i_wr_data(wdata),
        .i_rd_ren(ren), .i_clr_ovf(clr), .o_rd_data(o_rd_data),
        .o_rd_addr(o_rd_addr), .o_tvalid(o_tvalid), .o_tlast(o_tlast),
        .o_min_fill(o_min_fill), .o_overflow(o_overflow), .o_busy(o_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each lane is a FIFO queue; a block is a pop of one word per lane.
    typedef logic [W-1:0] word_t;
    typedef struct {
        logic [CH*W-1:0] data;
        int idx;
        int due;
    } beat_t;

    word_t mq [CH][$];
    beat_t pipe [$];
    int edge_n = 0;
    int m_state = 0;
    int m_idx = 0;
    int m_gap = 0;
    int m_min = 0;
    logic [CH-1:0] m_ovf = '0;
    bit m_tv = 0;
    bit m_last = 0;
    int m_addr = 0;
    logic [CH*W-1:0] m_data;
    bit chk_en = 0;

    always @(posedge clk) begin : model
        int pre [CH];
        int mn;
        bit iss;
        beat_t b;
        logic [CH-1:0] drop;
        edge_n++;
        if (rst) begin
            for (int c = 0; c < CH; c++) mq[c].delete();
            pipe.delete();
            m_state = 0; m_idx = 0; m_gap = 0; m_min = 0;
            m_ovf = '0; m_tv = 0; m_last = 0; m_addr = 0;
        end else begin
            mn = DEPTH;
            for (int c = 0; c < CH; c++) begin
                pre[c] = mq[c].size();
                if (pre[c] < mn) mn = pre[c];
            end
            iss = (m_state == 1) && ren;
            drop = '0;
            for (int c = 0; c < CH; c++) begin
                if (wen[c]) begin
                    if (pre[c] < DEPTH) mq[c].push_back(wdata[c*W +: W]);
                    else drop[c] = 1'b1;
                end
            end
            if (iss) begin
                for (int c = 0; c < CH; c++) begin
                    if (mq[c].size() > 0) b.data[c*W +: W] = mq[c].pop_front();
                    else b.data[c*W +: W] = 'x;
                end
                b.idx = m_idx;
                b.due = edge_n + RL - 1;
                pipe.push_back(b);
            end
            case (m_state)
                0: if (m_min >= BL) m_state = 1;
                1: if (iss) begin
                    if (m_idx == BL - 1) begin
                        m_idx = 0; m_gap = 0; m_state = 2;
                    end else m_idx++;
                end
                default: begin
                    m_gap++;
                    if (m_gap == 2) m_state = 0;
                end
            endcase
            m_min = mn;
            m_ovf = (clr ? '0 : m_ovf) | drop;
            m_tv = 0;
            if (pipe.size() > 0 && pipe[0].due == edge_n) begin
                b = pipe.pop_front();
                m_tv = 1; m_data = b.data; m_addr = b.idx;
                m_last = (b.idx == BL - 1);
            end
        end
    end

    typedef struct {
        logic [CH*W-1:0] data;
        int addr;
        bit last;
        int at;
    } cap_t;
    cap_t cap [$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tvalid", o_tvalid, m_tv);
            if (m_tv) begin
                chk("rd_data", o_rd_data, m_data);
                chk("rd_addr", o_rd_addr, m_addr);
                chk("tlast", o_tlast, m_last);
            end else begin
                chk("tlast_idle", o_tlast, 0);
            end
            chk("busy", o_busy, m_state == 1);
            chk("min_fill", o_min_fill, m_min);
            chk("overflow", o_overflow, m_ovf);
            if (o_tvalid === 1'b1)
                cap.push_back('{o_rd_data, int'(o_rd_addr), o_tlast, edge_n});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e_w, n0, nb;
        bit found;
        logic [CH*W-1:0] exp;
        wen = '0; wdata = '0; ren = 0; clr = 0; rst = 1;
        step(); step();
        rst = 0; chk_en = 1;
        chk("rst_tvalid", o_tvalid, 0);
        chk("rst_tlast", o_tlast, 0);
        chk("rst_addr", o_rd_addr, 0);
        chk("rst_min_fill", o_min_fill, 0);
        chk("rst_overflow", o_overflow, 0);
        chk("rst_busy", o_busy, 0);

        // 1: skewed lane writes, read enabled
        cap.delete();
        ren = 1;
        for (int j = 0; j < 7; j++) begin
            wen = '0;
            for (int c = 0; c < CH; c++) begin
                if (j >= c && j - c < 4) begin
                    wen[c] = 1'b1;
                    wdata[c*W +: W] = W'(c * 16 + j - c);
                end
            end
            step();
        end
        e_w = edge_n;
        wen = '0;
        repeat (15) step();
        chk("t1_beats", cap.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < cap.size()) begin
                exp = {W'(48 + k), W'(32 + k), W'(16 + k), W'(k)};
                chk("t1_data", cap[k].data, exp);
                chk("t1_addr", cap[k].addr, k);
                chk("t1_last", cap[k].last, k == 3);
            end
        end
        if (cap.size() > 0) chk("t1_latency", cap[0].at - e_w, 4);

        // 2: toggled read enable
        cap.delete();
        ren = 0;
        wen = '1;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < CH; c++) wdata[c*W +: W] = W'(16'h200 + c * 16 + k);
            step();
        end
        wen = '0;
        for (int j = 0; j < 24; j++) begin
            ren = j[0];
            step();
        end
        ren = 0;
        repeat (6) step();
        chk("t2_beats", cap.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < cap.size()) begin
                chk("t2_addr", cap[k].addr, k);
                chk("t2_lane0", cap[k].data[W-1:0], 16'h200 + k);
                if (k > 0) chk("t2_spacing", cap[k].at - cap[k-1].at, 2);
            end
        end

        // 3: overflow on lane 0
        wen = 4'b0001;
        for (int k = 0; k < 9; k++) begin
            wdata[W-1:0] = W'(16'h300 + k);
            step();
        end
        wen = '0;
        chk("t3_overflow", o_overflow, 4'b0001);
        chk("t3_min_fill", o_min_fill, 0);
        clr = 1;
        step();
        clr = 0;
        chk("t3_cleared", o_overflow, 0);
        rst = 1;
        step();
        rst = 0;
        chk("t3_rst_fill", o_min_fill, 0);

        // 4: continuous stream across pointer wrap
        cap.delete();
        ren = 1;
        wen = '1;
        for (int k = 0; k < 12; k++) begin
            for (int c = 0; c < CH; c++) wdata[c*W +: W] = W'(16'h400 + c * 32 + k);
            step();
        end
        wen = '0;
        repeat (25) step();
        chk("t4_beats", cap.size(), 12);
        for (int i = 0; i < 12; i++) begin
            if (i < cap.size()) begin
                exp = {W'(16'h460 + i), W'(16'h440 + i), W'(16'h420 + i), W'(16'h400 + i)};
                chk("t4_data", cap[i].data, exp);
                chk("t4_addr", cap[i].addr, i % 4);
                chk("t4_last", cap[i].last, (i % 4) == 3);
            end
        end
        chk("t4_overflow", o_overflow, 0);

        // 5: reset on the second beat
        wen = '1;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < CH; c++) wdata[c*W +: W] = W'(16'h500 + c * 16 + k);
            step();
        end
        wen = '0;
        found = 0;
        for (int j = 0; j < 20 && !found; j++) begin
            if (o_tvalid === 1'b1 && o_rd_addr == 1) begin
                found = 1;
                rst = 1;
                step();
                rst = 0;
            end else begin
                step();
            end
        end
        chk("t5_found", found, 1);
        chk("t5_tvalid", o_tvalid, 0);
        chk("t5_busy", o_busy, 0);
        chk("t5_min_fill", o_min_fill, 0);
        n0 = cap.size();
        repeat (10) step();
        chk("t5_quiet", cap.size() - n0, 0);
        wen = '1;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < CH; c++) wdata[c*W +: W] = W'(16'h580 + c * 16 + k);
            step();
        end
        wen = '0;
        repeat (15) step();
        chk("t5_resume", cap.size() - n0, 4);

        // 6: write to a full lane in the same cycle as a read issue
        ren = 0;
        for (int k = 0; k < 8; k++) begin
            wen = (k < 4) ? 4'b1111 : 4'b0100;
            for (int c = 0; c < CH; c++) wdata[c*W +: W] = W'(16'h600 + c * 16 + k);
            step();
        end
        wen = '0;
        nb = 0;
        while (o_busy !== 1'b1 && nb < 10) begin
            step();
            nb++;
        end
        chk("t6_busy", o_busy, 1);
        ren = 1;
        wen = 4'b0100;
        wdata[2*W +: W] = 16'h6ff;
        step();
        wen = '0;
        ren = 0;
        chk("t6_overflow", o_overflow, 4'b0100);
        chk("t6_occ2", mq[2].size(), 7);
        chk("t6_occ0", mq[0].size(), 3);
        ren = 1;
        repeat (10) step();
        ren = 0;
        repeat (3) step();
        chk("t6_occ2_end", mq[2].size(), 4);
        chk("t6_min_end", o_min_fill, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
